// File: rtl/cpu_ops_pkg.sv
// Shared operator codes, precedence helpers and scheduler state encoding for the
// calculator CPU's infix-to-postfix path.
package cpu_ops_pkg;

  localparam int CO_OK = 0;
  localparam int CO_LP = 1;
  localparam int CO_RP = 2;
  localparam int CO_AD = 3;
  localparam int CO_SB = 4;
  localparam int CO_MU = 5;
  localparam int CO_DI = 6;
  localparam int CO_PS = 7;
  localparam int CO_NS = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMP,
    ST_POP,
    ST_DROP_LP,
    ST_FLUSH,
    ST_DONE,
    ST_ERR
  } sched_state_t;

  // Unknown codes land in the default arm: level 0, binary, never X.
  function automatic logic [1:0] prec_level(input int unsigned code);
    logic [1:0] lvl;
    case (code)
      CO_AD, CO_SB: lvl = 2'd1;
      CO_MU, CO_DI: lvl = 2'd2;
      CO_PS, CO_NS: lvl = 2'd3;
      default:      lvl = 2'd0;
    endcase
    return lvl;
  endfunction

  function automatic logic is_unary(input int unsigned code);
    return (code == CO_PS) || (code == CO_NS);
  endfunction

endpackage

// File: rtl/op_lifo.sv
// Register-based LIFO holding pending operator codes; exposes top of stack and occupancy.
module op_lifo #(
  parameter int DEPTH = 16,
  parameter int W     = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     top,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem [DEPTH];
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] top_idx;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CNT_W'(DEPTH));
  assign wr_idx  = IDX_W'(cnt);
  assign top_idx = IDX_W'(cnt - 1'b1);
  assign top     = empty ? '0 : mem[top_idx];
  assign count   = cnt;

  // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (push && !full) begin
      cnt <= cnt + 1'b1;
    end else if (pop && !empty) begin
      cnt <= cnt - 1'b1;
    end
  end

  // NOTE: the storage array is deliberately not reset; the occupancy count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push && !full && !clr) begin
      mem[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/op_stack_sched.sv
// Shunting-yard operator-stack scheduler: stacks incoming operators and emits them in evaluation order.
// Define OPSTK_LEFT_ASSOC_EN to make equal-level binary operators reduce (left-associative).
module op_stack_sched
  import cpu_ops_pkg::*;
#(
  parameter  int CO_N  = 4,
  parameter  int DEPTH = 16,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [CO_N-1:0]  in_op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [CO_N-1:0]  out_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             done,
  output logic             err_overflow,
  output logic             err_paren,
  output logic [CNT_W-1:0] depth
);

`ifdef OPSTK_LEFT_ASSOC_EN
  localparam logic LEFT_ASSOC = 1'b1;
`else
  localparam logic LEFT_ASSOC = 1'b0;
`endif

  sched_state_t    state, state_nxt;
  logic [CO_N-1:0] b_op;
  logic [CO_N-1:0] top_op;
  logic            stk_empty, stk_full;
  logic            push, pop;
  logic            set_ovf, set_par;
  logic            load_b;
  logic [1:0]      lvl_a, lvl_b;
  logic            reduce;

  op_lifo #(
    .DEPTH (DEPTH),
    .W     (CO_N),
    .CNT_W (CNT_W)
  ) u_lifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .push  (push),
    .pop   (pop),
    .din   (b_op),
    .top   (top_op),
    .count (depth),
    .empty (stk_empty),
    .full  (stk_full)
  );

  assign lvl_a  = prec_level(32'(top_op));
  assign lvl_b  = prec_level(32'(b_op));
  // Unary PS/NS never reduce on a tie, which keeps them right-associative in both builds.
  assign reduce = (lvl_a > lvl_b) ||
                  (LEFT_ASSOC && (lvl_a == lvl_b) && !is_unary(32'(b_op)));

  // NOTE: every combinational output gets a default first so no path leaves a latch behind.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    set_ovf   = 1'b0;
    set_par   = 1'b0;
    load_b    = 1'b0;

    case (state)
      ST_IDLE: begin
        in_ready = rst_n;
        if (in_valid && in_ready) begin
          load_b    = 1'b1;
          state_nxt = ST_CMP;
        end
      end

      ST_CMP: begin
        if (b_op == CO_N'(CO_RP)) begin
          if (stk_empty) begin
            set_par   = 1'b1;
            state_nxt = ST_ERR;
          end else if (top_op == CO_N'(CO_LP)) begin
            state_nxt = ST_DROP_LP;
          end else begin
            state_nxt = ST_POP;
          end
        end else if (b_op == CO_N'(CO_OK)) begin
          state_nxt = ST_FLUSH;
        end else if ((b_op != CO_N'(CO_LP)) && !stk_empty &&
                     (top_op != CO_N'(CO_LP)) && reduce) begin
          state_nxt = ST_POP;
        end else if (stk_full) begin
          set_ovf   = 1'b1;
          state_nxt = ST_ERR;
        end else begin
          push      = 1'b1;
          state_nxt = ST_IDLE;
        end
      end

      ST_POP: begin
        out_valid = 1'b1;
        if (out_ready) begin
          pop       = 1'b1;
          state_nxt = ST_CMP;
        end
      end

      ST_DROP_LP: begin
        pop       = 1'b1;
        state_nxt = ST_IDLE;
      end

      ST_FLUSH: begin
        if (stk_empty) begin
          state_nxt = ST_DONE;
        end else if (top_op == CO_N'(CO_LP)) begin
          set_par   = 1'b1;
          state_nxt = ST_ERR;
        end else begin
          out_valid = 1'b1;
          pop       = out_ready;
        end
      end

      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end

      ST_ERR:  state_nxt = ST_ERR;

      default: state_nxt = ST_IDLE;
    endcase
  end

  // The stack top is frozen while the execute unit stalls, so out_op stays stable.
  assign out_op = out_valid ? top_op : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      b_op         <= '0;
      err_overflow <= 1'b0;
      err_paren    <= 1'b0;
    end else if (clr) begin
      state        <= ST_IDLE;
      b_op         <= '0;
      err_overflow <= 1'b0;
      err_paren    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load_b) begin
        b_op <= in_op;
      end
      if (set_ovf) begin
        err_overflow <= 1'b1;
      end
      if (set_par) begin
        err_paren <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_op_stack_sched.sv
// Self-checking bench for op_stack_sched (DEPTH=4): directed and random token streams
// compared against a queue-based shunting-yard reference model.
module tb_op_stack_sched;

  localparam int CO_N  = 4;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

`ifdef OPSTK_LEFT_ASSOC_EN
  localparam bit LEFT = 1'b1;
`else
  localparam bit LEFT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clr = 1'b0;
  logic [CO_N-1:0]  in_op = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [CO_N-1:0]  out_op;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             done;
  logic             err_overflow;
  logic             err_paren;
  logic [CNT_W-1:0] depth;

  int total = 0;
  int bad   = 0;

  int exp_out[$];
  int exp_done, exp_ovf, exp_par, exp_depth, exp_acc;

  op_stack_sched #(.CO_N(CO_N), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (clr),
    .in_op        (in_op),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_op       (out_op),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .done         (done),
    .err_overflow (err_overflow),
    .err_paren    (err_paren),
    .depth        (depth)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int lvl(input int c);
    case (c)
      3, 4:    return 1;
      5, 6:    return 2;
      7, 8:    return 3;
      default: return 0;
    endcase
  endfunction

  // Reference: textbook shunting-yard over a queue used as a bounded stack.
  task automatic model(input int toks[$]);
    int  stk[$];
    bit  stop;
    exp_out.delete();
    exp_done = 0; exp_ovf = 0; exp_par = 0; exp_acc = 0;
    stop = 0;
    foreach (toks[k]) begin
      int b;
      if (stop) break;
      b = toks[k];
      exp_acc++;
      if (b == 2) begin
        forever begin
          if (stk.size() == 0) begin exp_par = 1; stop = 1; break; end
          if (stk[$] == 1) begin void'(stk.pop_back()); break; end
          exp_out.push_back(stk.pop_back());
        end
      end else if (b == 0) begin
        forever begin
          if (stk.size() == 0) begin exp_done++; break; end
          if (stk[$] == 1) begin exp_par = 1; stop = 1; break; end
          exp_out.push_back(stk.pop_back());
        end
      end else begin
        forever begin
          if (b != 1 && stk.size() != 0 && stk[$] != 1 &&
              (lvl(stk[$]) > lvl(b) ||
               (LEFT && lvl(stk[$]) == lvl(b) && b != 7 && b != 8))) begin
            exp_out.push_back(stk.pop_back());
          end else begin
            if (stk.size() == DEPTH) begin exp_ovf = 1; stop = 1; end
            else stk.push_back(b);
            break;
          end
        end
      end
    end
    exp_depth = stk.size();
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    #1;
    check("clr.depth", depth, 0);
    check("clr.err", {err_overflow, err_paren}, 0);
    check("clr.in_ready", in_ready, 1);
    check("clr.out_valid", out_valid, 0);
  endtask

  task automatic run_seq(input string name, input int toks[$], input bit rnd_ready);
    int got[$];
    int idx, dones, cycles, n;
    model(toks);
    n = toks.size();
    idx = 0; dones = 0; cycles = 0;
    while (idx < n && !(err_overflow || err_paren) && cycles < 2000) begin
      @(negedge clk);
      in_valid  = $urandom_range(3) != 0;
      in_op     = CO_N'(toks[idx]);
      out_ready = rnd_ready ? ($urandom_range(1) == 1) : 1'b1;
      #1;
      if (out_valid && out_ready) got.push_back(int'(out_op));
      if (done) dones++;
      if (in_valid && in_ready) idx++;
      cycles++;
    end
    repeat (40) begin
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #1;
      if (out_valid && out_ready) got.push_back(int'(out_op));
      if (done) dones++;
    end
    check({name, ".accepted"}, idx, exp_acc);
    check({name, ".n_out"}, got.size(), exp_out.size());
    foreach (exp_out[k])
      if (k < got.size()) check($sformatf("%s.out%0d", name, k), got[k], exp_out[k]);
    check({name, ".done"}, dones, exp_done);
    check({name, ".err_overflow"}, err_overflow, exp_ovf);
    check({name, ".err_paren"}, err_paren, exp_par);
    check({name, ".depth"}, depth, exp_depth);
    check({name, ".in_ready"}, in_ready, !(exp_ovf || exp_par));
  endtask

  task automatic send(input int op);
    int cycles = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = CO_N'(op);
    #1;
    while (!in_ready && cycles < 50) begin
      @(negedge clk);
      #1;
      cycles++;
    end
    check("send.in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    int tq[$];
    // Reset state while held in reset.
    #12;
    check("rst.in_ready", in_ready, 0);
    check("rst.depth", depth, 0);
    check("rst.out_valid", out_valid, 0);
    check("rst.out_op", out_op, 0);
    check("rst.done", done, 0);
    check("rst.err", {err_overflow, err_paren}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst.in_ready_after", in_ready, 1);

    tq = {3, 5, 0};          run_seq("ad_mu_ok", tq, 1'b0); do_clr();
    tq = {3, 4, 0};          run_seq("ad_sb_ok", tq, 1'b0); do_clr();
    tq = {5, 1, 3, 2, 0};    run_seq("paren", tq, 1'b1);    do_clr();
    tq = {1, 1, 1, 1, 1};    run_seq("overflow", tq, 1'b0); do_clr();
    tq = {2};                run_seq("rp_empty", tq, 1'b0); do_clr();
    tq = {1, 0};             run_seq("lp_flush", tq, 1'b0); do_clr();
    tq = {7, 8, 3, 7, 0};    run_seq("unary", tq, 1'b1);    do_clr();
    tq = {12, 3, 15, 0};     run_seq("unknown", tq, 1'b1);  do_clr();

    // Stall: MU stays on out_op while out_ready is low.
    out_ready = 1'b0;
    send(5);
    send(3);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("stall%0d.out_valid", i), out_valid, 1);
      check($sformatf("stall%0d.out_op", i), out_op, 5);
      check($sformatf("stall%0d.depth", i), depth, 1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    check("stall.popped", depth, 0);
    @(negedge clk);
    #1;
    check("stall.pushed", depth, 1);
    check("stall.idle", in_ready, 1);
    do_clr();

    // Asynchronous reset in the middle of a stream.
    send(1);
    send(1);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst.depth", depth, 0);
    check("arst.in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int s = 0; s < 40; s++) begin
      int len;
      tq.delete();
      len = $urandom_range(3, 10);
      for (int k = 0; k < len; k++) begin
        int v;
        v = $urandom_range(99);
        if (v < 55)      tq.push_back(3 + v % 6);
        else if (v < 70) tq.push_back(1);
        else if (v < 80) tq.push_back(2);
        else if (v < 88) tq.push_back(9 + v % 7);
        else             tq.push_back(0);
      end
      if ($urandom_range(9) < 7) tq.push_back(0);
      run_seq($sformatf("rnd%0d", s), tq, 1'b1);
      do_clr();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/op_stack_sched.md
Name: op_stack_sched

Overview:
- Sequential operator-stack scheduler for the calculator CPU's infix-to-postfix (shunting-yard) path.
- Accepts a stream of operator codes and holds pending operators on an internal stack of depth DEPTH.
- Emits operators in evaluation order to the execute unit over a valid/ready handshake.
- Successor to the combinational precedence table: adds parametrised numeric precedence levels, associativity, paren matching, flush and error detection.

Parameters:
- CO_N, 4, operator code width (must hold all CO_* codes).
- DEPTH, 16, operator stack entries (≥2).
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous soft clear; highest priority after reset.
- in_op  in  CO_N  incoming operator code.
- in_valid  in  1  in_op valid.
- in_ready  out  1  scheduler can accept in_op.
- out_op  out  CO_N  operator to execute.
- out_valid  out  1  out_op valid.
- out_ready  in  1  execute unit accepts out_op.
- done  out  1  one-cycle pulse after a CO_OK flush completes cleanly.
- err_overflow  out  1  sticky: push attempted while full.
- err_paren  out  1  sticky: unmatched RP, or LP found during flush.
- depth  out  CNT_W  current stack occupancy.

Behaviour:
- Reset / clr: stack empty, depth=0, state IDLE, out_valid=0, in_ready=0 during reset then 1, done=0, errors=0, out_op=0.
- Levels (package function): OK/LP/RP=0, AD/SB=1, MU/DI=2, PS/NS=3. PS/NS are unary and right-associative; AD/SB/MU/DI are binary.
- States: IDLE, CMP, POP, DROP_LP, FLUSH, DONE, ERR.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, latch in_op as B and go to CMP.
  - Handshake occurs only in IDLE.
- CMP (one cycle), with A = top of stack:
  - B=LP: push.
  - B=RP: if empty → ERR (err_paren); if A=LP → DROP_LP; else → POP.
  - B=OK: → FLUSH.
  - Other B: if empty or A=LP → push. Else reduce when lvl(A)>lvl(B), or lvl(A)==lvl(B) with B binary (left-assoc, see optional feature); otherwise push.
  - Push: if depth==DEPTH → ERR (err_overflow), stack unchanged; else write, depth+1, → IDLE.
- POP:
  - out_valid=1, out_op=top.
  - On out_ready: depth−1, return to CMP with the same B.
  - out_op is held stable while out_valid & !out_ready.
- DROP_LP: discard LP (depth−1), discard RP, → IDLE. No output.
- FLUSH:
  - If empty → DONE.
  - If top=LP → ERR (err_paren).
  - Else out_valid=1, out_op=top; pop on out_ready and stay in FLUSH.
- DONE: done=1 for one cycle, → IDLE.
- ERR: in_ready=0, out_valid=0; exit only via clr or reset.
- Latency: accept-to-in_ready for a pure push is 2 cycles (IDLE→CMP→IDLE). Each emitted operator adds ≥1 POP cycle.
- Unknown/undefined codes: treated as level 0 binary; never X-propagated.
- Reset mid-operation: asynchronous, everything returns to reset values immediately.
- clr mid-POP: out_valid drops the next cycle; no pop performed.

Optional Feature:
- OPSTK_LEFT_ASSOC_EN defined: equal-level binary operators reduce (left-associative). Example: AD,SB emits AD then SB.
- Undefined: equal-level operators always push, reproducing the legacy table behaviour. Example: AD,SB emits SB then AD.
- PS/NS remain right-associative in both builds.

Decomposition:
- Shared package cpu_ops_pkg holds: CO_* code localparams (OK=0, LP=1, RP=2, AD=3, SB=4, MU=5, DI=6, PS=7, NS=8), the prec_level function, the is_unary function, and the state enum.
- One sub-module: op_lifo (DEPTH×CO_N register stack with push, pop, top and depth). The FSM stays in op_stack_sched.

Test Plan:
- AD, MU, OK → out MU, AD; done pulse; depth returns to 0.
- With OPSTK_LEFT_ASSOC_EN: AD, SB, OK → out AD, SB. Without it: SB, AD.
- MU, LP, AD, RP, OK → out AD, MU; no err_paren; DROP_LP visible via depth 3→1.
- DEPTH=4: LP×5 → err_overflow=1 on the 5th, depth=4, in_ready=0; clr → depth=0, errors cleared, in_ready=1.
- RP on empty stack → err_paren=1. Separately, LP, OK → err_paren during FLUSH.
- MU, AD with out_ready held low 3 cycles → out_op=MU stable, out_valid=1 throughout; pop occurs only on the out_ready cycle.
